// File: rtl/net_arbiter.sv
// Round-robin scheduler sharing one net instance among N requesters; drives the net launch protocol.
// Optional watchdog on the WAIT state is enabled by defining NET_ARB_TIMEOUT_EN.
module net_arbiter #(
    parameter int N       = 4,
    parameter int I       = 2,
    parameter int O       = 1,
    parameter int TIMEOUT = 1024
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N-1:0]         req,
    input  logic [N*32*I-1:0]    x_in,
    output logic [N-1:0]         ack,
    output logic [32*O-1:0]      y_out,
    output logic                 err,
    output logic                 busy,
    output logic                 net_rst_n,
    output logic                 net_start,
    output logic [32*I-1:0]      net_x,
    input  logic [32*O-1:0]      net_y,
    input  logic                 net_done
);

    localparam int PW = $clog2(N);
    localparam int XW = 32 * I;
    localparam int YW = 32 * O;

    generate
        if (N < 2 || N > 16 || I < 1 || O < 1 || TIMEOUT < 1) begin : g_param_check
            $error("net_arbiter: unsupported parameter set");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_RESP
    } state_e;

    state_e          state_q;
    logic [PW-1:0]   ptr_q;
    logic [PW-1:0]   winner_q;
    logic [N-1:0]    ack_q;
    logic [YW-1:0]   y_q;
    logic            busy_q;
    logic            net_rst_n_q;
    logic            net_start_q;
    logic [XW-1:0]   net_x_q;
    logic            done_q;

    logic [PW-1:0]   winner_d;
    logic            found_d;
    logic [XW-1:0]   slice_d;
    logic [N-1:0]    ack_d;
    logic [PW-1:0]   ptr_d;
    logic            done_rise;

    // Search starts at the pointer and wraps, so the last-served requester goes to the back.
    always_comb begin
        winner_d = ptr_q;
        found_d  = 1'b0;
        for (int i = 0; i < N; i++) begin
            logic [PW-1:0] idx;
            idx = PW'((int'(ptr_q) + i) % N);
            if (!found_d && req[idx]) begin
                winner_d = idx;
                found_d  = 1'b1;
            end
        end
    end

    always_comb begin
        slice_d = '0;
        ack_d   = '0;
        for (int k = 0; k < N; k++) begin
            if (winner_d == PW'(k)) begin
                slice_d = x_in[k*XW +: XW];
            end
            if (winner_q == PW'(k)) begin
                ack_d[k] = 1'b1;
            end
        end
    end

    assign ptr_d     = (winner_q == PW'(N - 1)) ? '0 : winner_q + PW'(1);
    assign done_rise = net_done & ~done_q;

`ifdef NET_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    logic [TW-1:0] tmo_q;
    logic          err_q;
    logic          tmo_hit;

    assign tmo_hit = (tmo_q == TW'(TIMEOUT - 1));
    assign err     = err_q;
`else
    assign err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            ptr_q       <= '0;
            winner_q    <= '0;
            ack_q       <= '0;
            y_q         <= '0;
            busy_q      <= 1'b0;
            net_rst_n_q <= 1'b0;
            net_start_q <= 1'b0;
            net_x_q     <= '0;
            done_q      <= 1'b0;
`ifdef NET_ARB_TIMEOUT_EN
            tmo_q       <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            ack_q  <= '0;
            done_q <= net_done;
`ifdef NET_ARB_TIMEOUT_EN
            err_q  <= 1'b0;
`endif
            case (state_q)
                S_IDLE: begin
                    if (found_d) begin
                        winner_q    <= winner_d;
                        net_x_q     <= slice_d;
                        net_start_q <= 1'b1;
                        busy_q      <= 1'b1;
                        state_q     <= S_LAUNCH;
                    end
                end
                S_LAUNCH: begin
                    // A done level left over from before launch must not count as completion.
                    net_start_q <= 1'b0;
                    net_rst_n_q <= 1'b1;
                    done_q      <= 1'b1;
`ifdef NET_ARB_TIMEOUT_EN
                    tmo_q       <= '0;
`endif
                    state_q     <= S_WAIT;
                end
                S_WAIT: begin
                    if (done_rise) begin
                        y_q         <= net_y;
                        ack_q       <= ack_d;
                        net_rst_n_q <= 1'b0;
                        state_q     <= S_RESP;
                    end
`ifdef NET_ARB_TIMEOUT_EN
                    else if (tmo_hit) begin
                        y_q         <= {O{QNAN}};
                        err_q       <= 1'b1;
                        ack_q       <= ack_d;
                        net_rst_n_q <= 1'b0;
                        state_q     <= S_RESP;
                    end else begin
                        tmo_q <= tmo_q + TW'(1);
                    end
`endif
                end
                S_RESP: begin
                    ptr_q   <= ptr_d;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign ack       = ack_q;
    assign y_out     = y_q;
    assign busy      = busy_q;
    assign net_rst_n = net_rst_n_q;
    assign net_start = net_start_q;
    assign net_x     = net_x_q;

endmodule

// File: tb/tb_net_arbiter.sv
// Self-checking bench for net_arbiter: vector table, hand-written corner sequences and a
// randomized run against a transaction-level round-robin model with a behavioural net.
module tb_net_arbiter;

    localparam int N   = 4;
    localparam int I   = 2;
    localparam int O   = 1;
    localparam int TMO = 16;

    logic               clk   = 1'b0;
    logic               rst_n = 1'b0;
    logic [N-1:0]       req   = '0;
    logic [N*32*I-1:0]  xIn   = '0;
    logic [N-1:0]       ack;
    logic [32*O-1:0]    y_out;
    logic               err;
    logic               busy;
    logic               net_rst_n;
    logic               net_start;
    logic [32*I-1:0]    net_x;
    logic [32*O-1:0]    net_y;
    logic               net_done;

    int          netCnt;
    int          netLatency = 5;
    logic [31:0] netYCur    = '0;

    int total  = 0;
    int bad    = 0;
    int refPtr = 0;

    net_arbiter #(.N(N), .I(I), .O(O), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .x_in(xIn), .ack(ack), .y_out(y_out),
        .err(err), .busy(busy), .net_rst_n(net_rst_n), .net_start(net_start),
        .net_x(net_x), .net_y(net_y), .net_done(net_done)
    );

    always #5 clk = ~clk;

    // Behavioural net: raises done netLatency cycles after leaving reset; latency 0 means never.
    always @(posedge clk) begin
        if (!net_rst_n) begin
            netCnt   <= 0;
            net_done <= 1'b0;
        end else begin
            netCnt <= netCnt + 1;
            if (netCnt + 1 == netLatency) net_done <= 1'b1;
        end
    end

    assign net_y = net_done ? netYCur : 32'hDEAD_BEEF;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int refWinner(input logic [N-1:0] r);
        for (int i = 0; i < N; i++) begin
            if (r[(refPtr + i) % N]) return (refPtr + i) % N;
        end
        return -1;
    endfunction

    // Runs one transaction from an IDLE negedge; expCycles counts from the IDLE sample to ack.
    task automatic applyStimulus(input logic [N-1:0] r, input int lat, input logic [31:0] yv,
                                 input int expW, input int expCycles, input bit expErr,
                                 input logic [31:0] expY, input bit scramble);
        logic [63:0] expSlice;
        int          k;
        bit          seen;
        checkOutput("idle_busy", busy, 0);
        req        = r;
        netLatency = lat;
        netYCur    = yv;
        expSlice   = xIn[expW*64 +: 64];
        @(negedge clk);
        checkOutput("launch_start", net_start, 1);
        checkOutput("launch_rst", net_rst_n, 0);
        checkOutput("launch_x", net_x, expSlice);
        checkOutput("launch_busy", busy, 1);
        seen = 1'b0;
        k    = 1;
        while (!seen && k < expCycles + 6) begin
            if (scramble) begin
                req = N'($urandom);
                xIn = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            end
            @(negedge clk);
            k++;
            if (ack != '0) seen = 1'b1;
        end
        checkOutput("ack_seen", seen, 1);
        if (seen) begin
            checkOutput("ack_time", k, expCycles);
            checkOutput("ack_onehot", ack, 64'(1) << expW);
            checkOutput("y_out", y_out, expY);
            checkOutput("err", err, expErr);
            checkOutput("hold_x", net_x, expSlice);
        end
        @(negedge clk);
        checkOutput("ack_pulse", ack, 0);
        checkOutput("idle_after", busy, 0);
        req    = '0;
        refPtr = (expW + 1) % N;
    endtask

    typedef struct {
        logic [N-1:0] r;
        int           lat;
        logic [31:0]  y;
        int           expW;
    } vec_t;

    vec_t tbl[10];

    initial begin
        bit          sawAck;
        bit          sawBusy;
        logic [N-1:0] r;
        int          w;

        tbl[0] = '{4'b1111, 5, 32'hA000_0000, 0};
        tbl[1] = '{4'b1111, 3, 32'hA000_0001, 1};
        tbl[2] = '{4'b1111, 2, 32'hA000_0002, 2};
        tbl[3] = '{4'b1111, 7, 32'hA000_0003, 3};
        tbl[4] = '{4'b1111, 1, 32'hA000_0004, 0};
        tbl[5] = '{4'b0010, 5, 32'h3F7F_0000, 1};
        tbl[6] = '{4'b1000, 4, 32'hB000_0006, 3};
        tbl[7] = '{4'b1001, 2, 32'hB000_0007, 0};
        tbl[8] = '{4'b1001, 3, 32'hB000_0008, 3};
        tbl[9] = '{4'b0100, 6, 32'hB000_0009, 2};

        xIn[63:0]    = 64'h1111_1111_2222_2222;
        xIn[127:64]  = 64'h0000_0000_3F80_0000;
        xIn[191:128] = 64'h3333_3333_4444_4444;
        xIn[255:192] = 64'h5555_5555_6666_6666;

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("rst_ack", ack, 0);
        checkOutput("rst_y", y_out, 0);
        checkOutput("rst_err", err, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_net_rst_n", net_rst_n, 0);
        checkOutput("rst_net_start", net_start, 0);
        checkOutput("rst_net_x", net_x, 0);
        rst_n  = 1'b1;
        refPtr = 0;
        @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            applyStimulus(tbl[i].r, tbl[i].lat, tbl[i].y, tbl[i].expW, tbl[i].lat + 3,
                          1'b0, tbl[i].y, 1'b0);
        end

        sawBusy = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (busy) sawBusy = 1'b1;
        end
        checkOutput("no_req_idle", sawBusy, 0);

        for (int n = 0; n < 40; n++) begin
            r   = N'($urandom_range(1, 15));
            w   = refWinner(r);
            xIn = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            if ($urandom_range(0, 3) == 0) repeat (2) @(negedge clk);
            begin
                int          lat;
                logic [31:0] yv;
                lat = $urandom_range(1, 9);
                yv  = $urandom;
                applyStimulus(r, lat, yv, w, lat + 3, 1'b0, yv, 1'b1);
            end
        end

        applyStimulus(4'b0010, 2, 32'hC000_0001, refWinner(4'b0010), 5, 1'b0, 32'hC000_0001, 1'b0);

        req        = 4'b0100;
        netLatency = 20;
        @(negedge clk);
        checkOutput("abort_launch", net_start, 1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        req   = '0;
        @(negedge clk);
        checkOutput("abort_busy", busy, 0);
        checkOutput("abort_ack", ack, 0);
        checkOutput("abort_net_rst_n", net_rst_n, 0);
        rst_n   = 1'b1;
        sawAck  = 1'b0;
        sawBusy = 1'b0;
        repeat (25) begin
            @(negedge clk);
            if (ack != '0) sawAck = 1'b1;
            if (busy) sawBusy = 1'b1;
        end
        checkOutput("abort_no_ack", sawAck, 0);
        checkOutput("abort_stays_idle", sawBusy, 0);
        refPtr = 0;
        applyStimulus(4'b1111, 2, 32'hC000_0002, 0, 5, 1'b0, 32'hC000_0002, 1'b0);

`ifdef NET_ARB_TIMEOUT_EN
        applyStimulus(4'b0001, 0, 32'h0, refWinner(4'b0001), TMO + 2, 1'b1, 32'h7FC0_0000, 1'b0);
`else
        req        = 4'b0001;
        netLatency = 0;
        @(negedge clk);
        req    = '0;
        sawAck = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (ack != '0) sawAck = 1'b1;
        end
        checkOutput("hang_busy", busy, 1);
        checkOutput("hang_no_ack", sawAck, 0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("hang_reset_busy", busy, 0);
        refPtr = 0;
`endif

        applyStimulus(4'b1010, 4, 32'hC000_0003, refWinner(4'b1010), 7, 1'b0, 32'hC000_0003, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/net_arbiter.md
# net_arbiter

Round-robin scheduler that shares one `net` inference instance among `N` requesters. It accepts per-requester input vectors of IEEE-754 single-precision values and picks one pending requester per transaction. It drives the net's reset/start launch protocol, waits for `done`, and returns the net output with a one-cycle acknowledge to the granted requester. It sits between the requesting units and the single `net` datapath.

## Interface
Parameters:
- `N`, 4: number of requesters (2..16).
- `I`, 2: net input count, 32-bit floats per vector.
- `O`, 1: net output count, 32-bit floats per vector.
- `TIMEOUT`, 1024: watchdog limit in cycles, used only with `NET_ARB_TIMEOUT_EN`.

Ports:
- `clk`  in  1  single clock, all logic on posedge.
- `rst_n`  in  1  synchronous, active-low reset.
- `req`  in  N  per-requester request, level.
- `x_in`  in  N*32*I  concatenated input vectors; requester k occupies bits [32*I*(k+1)-1 : 32*I*k].
- `ack`  out  N  one-hot, one-cycle pulse: result for requester k is on `y_out`.
- `y_out`  out  32*O  result, valid only while `ack` is nonzero.
- `err`  out  1  timeout flag, qualified by `ack`; constant 0 when the macro is off.
- `busy`  out  1  high in any state other than IDLE.
- `net_rst_n`  out  1  to net `rst_n`.
- `net_start`  out  1  to net `start`.
- `net_x`  out  32*I  to net `x`.
- `net_y`  in  32*O  from net `y`.
- `net_done`  in  1  from net `done`.

## Operation
- FSM states: IDLE, LAUNCH, WAIT, RESP. All outputs are registered.
- IDLE:
  - `net_rst_n`=0, `net_start`=0.
  - If any `req` bit is set, select the winner: the first set bit at or above pointer `ptr`, wrapping modulo N.
  - Latch `x_in` slice of the winner into `net_x`, store the winner index, go to LAUNCH.
- LAUNCH (exactly 1 cycle): `net_rst_n`=0, `net_start`=1, `net_x` stable. Go to WAIT.
- WAIT:
  - `net_rst_n`=1, `net_start`=0.
  - Track `done_q` (registered `net_done`). A rising edge (`net_done` & !`done_q`) moves the FSM to RESP and latches `net_y`.
  - `net_done` already high on WAIT entry does not count as a rising edge; `done_q` is forced to 1 at LAUNCH.
- RESP (1 cycle):
  - `ack[winner]`=1, `y_out`=latched value.
  - `ptr` ← (winner+1) mod N.
  - Go to IDLE.
- `net_x` is held for the whole transaction. Changes on `x_in` after the IDLE sample are ignored.
- If the requester drops `req` during a transaction, the transaction still completes and `ack` still pulses.
- Requests that arrive during busy are not queued. The `req` level is re-evaluated at the next IDLE.
- Fairness: with all N requesting continuously, each requester is served exactly once per N transactions.
- Reset values: `ack`=0, `y_out`=0, `err`=0, `busy`=0, `net_rst_n`=0, `net_start`=0, `net_x`=0, `ptr`=0, state IDLE.
- `rst_n` low mid-transaction aborts it at the next edge: no `ack`, net held in reset.

## Timing
- Cycle t, IDLE samples `req`.
- t+1: LAUNCH, `net_start`=1.
- t+2: WAIT begins, `net_rst_n`=1.
- Rising `net_done` sampled at cycle d gives RESP at d+1, with `ack` and `y_out` valid. IDLE resumes at d+2.
- Minimum issue interval: net latency + 3 cycles. Back-to-back grants are allowed from the first IDLE cycle.
- `busy` rises at t+1 and falls at d+2.

## Configuration
- `NET_ARB_TIMEOUT_EN` defined:
  - A counter runs in WAIT.
  - After `TIMEOUT` cycles with no rising `net_done`, go to RESP with `err`=1, `y_out`=32'h7FC00000 (quiet NaN), and `ack` to the winner.
  - `ptr` advances as normal.
- Macro undefined: no counter; WAIT lasts indefinitely; `err` tied to 0.

## Test plan
- Reset: hold `rst_n`=0 for 3 cycles → all outputs at reset values, `net_rst_n`=0.
- Single request: `req`=4'b0010, x slice 1 = {32'h00000000, 32'h3f800000}, net model gives `done` after 5 cycles with y=32'h3f7f0000 → `net_x` matches at LAUNCH, `ack`=4'b0010 with `y_out`=32'h3f7f0000 exactly 8 cycles after the IDLE sample.
- Round-robin: `req`=4'b1111 held → `ack` order 0001, 0010, 0100, 1000, 0001.
- Pointer wrap: after serving requester 3, `req`=4'b1001 → requester 0 granted next, then requester 3.
- Reset mid-WAIT: assert `rst_n`=0 two cycles after LAUNCH → no `ack`, `busy`=0, `ptr`=0.
- Timeout (macro on, `TIMEOUT`=16): net never raises `done` → 16 cycles after WAIT entry, `ack` pulses with `err`=1 and `y_out`=32'h7FC00000. With the macro off, `busy` stays 1.
